// File: rtl/xmem_responder.sv
// ----------------------------------------------------------------------------
// xmem_responder
//
// Target-side responder for the external SRAM-style bus. It decodes a
// 2^WIN_BITS-word address window at WIN_BASE and stretches initiator cycles
// with memory_busy. Each access becomes one level-style req/ack transaction
// on a word-wide backing port.
//
// Ports
//   clock, reset_n        system clock, asynchronous active-low reset
//   sram_adr              23-bit word address from the initiator
//   addr_strobe           one-cycle pulse qualifying sram_adr
//   sram_ce/we/oe         active-low chip enable, write strobe, output enable
//   sram_be               active-low byte enables (bit 1 = data[15:8])
//   sram_dat_in           write data from the initiator
//   sram_dat_out          read data to the initiator (registered, held in HOLD)
//   sram_dat_oe           responder drives the data bus
//   use_memory_busy       combinational: sram_adr lies in the window
//   memory_busy           registered stall request
//   bk_req/bk_we          backing request (level) and direction (1 = write)
//   bk_addr               backing word address (WIN_BITS wide)
//   bk_be                 active-high byte enables
//   bk_wdata              backing write data
//   bk_rdata/bk_ack       backing read data and one-cycle acknowledge
//   proto_err             sticky: addr_strobe arrived while a backing access
//                         was outstanding
// ----------------------------------------------------------------------------
module xmem_responder #(
  parameter logic [22:0] WIN_BASE = 23'h080000,
  parameter int          WIN_BITS = 18
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [22:0]         sram_adr,
  input  logic                addr_strobe,
  input  logic                sram_ce,
  input  logic                sram_we,
  input  logic                sram_oe,
  input  logic [1:0]          sram_be,
  input  logic [15:0]         sram_dat_in,
  output logic [15:0]         sram_dat_out,
  output logic                sram_dat_oe,
  output logic                use_memory_busy,
  output logic                memory_busy,
  output logic                bk_req,
  output logic                bk_we,
  output logic [WIN_BITS-1:0] bk_addr,
  output logic [1:0]          bk_be,
  output logic [15:0]         bk_wdata,
  input  logic [15:0]         bk_rdata,
  input  logic                bk_ack,
  output logic                proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_BK   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t              state_reg,     state_next;
  logic                busy_reg,      busy_next;
  logic                req_reg,       req_next;
  logic                we_reg,        we_next;
  logic [WIN_BITS-1:0] addr_reg,      addr_next;
  logic [1:0]          be_reg,        be_next;
  logic [15:0]         wdata_reg,     wdata_next;
  logic [15:0]         dat_out_reg,   dat_out_next;
  logic                proto_err_reg, proto_err_next;

  // --------------------------------------------------------------------------
  // Window decode: only the bits above the window size take part.
  // --------------------------------------------------------------------------
  logic in_window;
  logic take_strobe;

  assign in_window   = (sram_adr[22:WIN_BITS] == WIN_BASE[22:WIN_BITS]);
  assign take_strobe = addr_strobe & in_window;

  // Active-low bus byte enables become active-high backing lane enables.
  logic [1:0] lane_en;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_en[gi] = ~sram_be[gi];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= 1'b0;
      req_reg       <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      be_reg        <= 2'b00;
      wdata_reg     <= 16'h0000;
      dat_out_reg   <= 16'h0000;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      busy_reg      <= busy_next;
      req_reg       <= req_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      be_reg        <= be_next;
      wdata_reg     <= wdata_next;
      dat_out_reg   <= dat_out_next;
      proto_err_reg <= proto_err_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    busy_next      = busy_reg;
    req_next       = req_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    be_next        = be_reg;
    wdata_next     = wdata_reg;
    dat_out_next   = dat_out_reg;
    proto_err_next = proto_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (take_strobe) begin
          addr_next  = sram_adr[WIN_BITS-1:0];
          busy_next  = 1'b1;
          state_next = ST_ARM;
        end
      end

      // Direction is unknown until CE and WE/OE show up; a CPU write drives
      // them one cycle after the strobe. WE wins over OE. With CE low but
      // neither strobe low yet, keep waiting.
      ST_ARM: begin
        if (sram_ce) begin
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else if (!sram_we) begin
          we_next    = 1'b1;
          wdata_next = sram_dat_in;
          be_next    = lane_en;
          req_next   = 1'b1;
          state_next = ST_BK;
        end else if (!sram_oe) begin
          we_next    = 1'b0;
          be_next    = lane_en;
          req_next   = 1'b1;
          state_next = ST_BK;
        end
      end

      ST_BK: begin
        // A new strobe cannot be honoured while the backing side is busy.
        if (addr_strobe) begin
          proto_err_next = 1'b1;
        end
        if (bk_ack) begin
          req_next   = 1'b0;
          busy_next  = 1'b0;
          if (!we_reg) begin
            dat_out_next = bk_rdata;
          end
          state_next = ST_HOLD;
        end
      end

      // A new in-window strobe takes precedence over CE rising: it starts a
      // fresh access exactly as it would from IDLE.
      ST_HOLD: begin
        if (take_strobe) begin
          addr_next  = sram_adr[WIN_BITS-1:0];
          busy_next  = 1'b1;
          state_next = ST_ARM;
        end else if (sram_ce) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign use_memory_busy = in_window;
  assign sram_dat_oe     = (state_reg == ST_HOLD) & ~we_reg & ~sram_ce & ~sram_oe;
  assign sram_dat_out    = dat_out_reg;
  assign memory_busy     = busy_reg;
  assign bk_req          = req_reg;
  assign bk_we           = we_reg;
  assign bk_addr         = addr_reg;
  assign bk_be           = be_reg;
  assign bk_wdata        = wdata_reg;
  assign proto_err       = proto_err_reg;

endmodule

// File: tb/tb_xmem_responder.sv
// ----------------------------------------------------------------------------
// tb_xmem_responder
//
// Table of accesses (reads, writes, out-of-window strobes) driven through the
// SRAM-side pins, plus hand sequences for abort, back-to-back with an illegal
// strobe during a backing access, and asynchronous reset mid-transaction.
// A backing-port model pops the expected request from a scoreboard queue when
// bk_req appears and acknowledges after the scheduled delay.
// ----------------------------------------------------------------------------
module tb_xmem_responder;

  logic        clock;
  logic        reset_n;
  logic [22:0] sram_adr;
  logic        addr_strobe;
  logic        sram_ce;
  logic        sram_we;
  logic        sram_oe;
  logic [1:0]  sram_be;
  logic [15:0] sram_dat_in;
  logic [15:0] sram_dat_out;
  logic        sram_dat_oe;
  logic        use_memory_busy;
  logic        memory_busy;
  logic        bk_req;
  logic        bk_we;
  logic [17:0] bk_addr;
  logic [1:0]  bk_be;
  logic [15:0] bk_wdata;
  logic [15:0] bk_rdata;
  logic        bk_ack;
  logic        proto_err;

  xmem_responder dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .sram_adr        (sram_adr),
    .addr_strobe     (addr_strobe),
    .sram_ce         (sram_ce),
    .sram_we         (sram_we),
    .sram_oe         (sram_oe),
    .sram_be         (sram_be),
    .sram_dat_in     (sram_dat_in),
    .sram_dat_out    (sram_dat_out),
    .sram_dat_oe     (sram_dat_oe),
    .use_memory_busy (use_memory_busy),
    .memory_busy     (memory_busy),
    .bk_req          (bk_req),
    .bk_we           (bk_we),
    .bk_addr         (bk_addr),
    .bk_be           (bk_be),
    .bk_wdata        (bk_wdata),
    .bk_rdata        (bk_rdata),
    .bk_ack          (bk_ack),
    .proto_err       (proto_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  int req_trains = 0;

  typedef struct {
    logic        wr;
    logic [17:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          delay;
  } sb_t;

  sb_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [22:0] adr;
    logic [1:0]  sbe;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          delay;
    logic        exp_win;
    logic [17:0] exp_addr;
    logic [1:0]  exp_be;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Backing-port model: pops the expected request when bk_req first appears,
  // compares it, then acks after 'delay' further cycles. Random read data is
  // driven at all other times so late sampling would be visible.
  // --------------------------------------------------------------------------
  logic m_active = 1'b0;
  int   m_cnt    = 0;
  sb_t  m_cur;

  initial begin
    bk_ack   = 1'b0;
    bk_rdata = 16'h0000;
    forever begin
      @(negedge clock);
      bk_ack   = 1'b0;
      bk_rdata = 16'($urandom);
      if (!reset_n) begin
        m_active = 1'b0;
      end else begin
        if (!m_active && bk_req === 1'b1) begin
          req_trains++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bk_req actual=1 required=0 t=%0t", $time);
          end else begin
            m_cur = sb_q.pop_front();
            chk("bk_we", bk_we, m_cur.wr);
            chk("bk_addr", bk_addr, m_cur.addr);
            chk("bk_be", bk_be, m_cur.be);
            if (m_cur.wr) chk("bk_wdata", bk_wdata, m_cur.wdata);
            m_active = 1'b1;
            m_cnt    = m_cur.delay;
          end
        end
        if (m_active) begin
          if (m_cnt == 0) begin
            bk_ack   = 1'b1;
            bk_rdata = m_cur.rdata;
            m_active = 1'b0;
          end else begin
            m_cnt--;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // One complete access from the initiator side.
  // --------------------------------------------------------------------------
  task automatic run_access(input vec_t v);
    int busy_cnt;
    int trains0;
    trains0 = req_trains;
    @(negedge clock);                        // cycle s
    sram_adr    = v.adr;
    addr_strobe = 1'b1;
    sram_ce     = 1'b1;
    sram_we     = 1'b1;
    sram_oe     = 1'b1;
    sram_be     = v.sbe;
    sram_dat_in = 16'h0000;
    #1 chk("use_memory_busy", use_memory_busy, v.exp_win);
    if (v.exp_win) sb_q.push_back('{v.wr, v.exp_addr, v.exp_be, v.wdata, v.rdata, v.delay});
    @(negedge clock);                        // s+1
    addr_strobe = 1'b0;
    chk("busy_s1", memory_busy, v.exp_win);
    sram_ce = 1'b0;
    if (v.wr) begin
      sram_we     = 1'b0;
      sram_dat_in = v.wdata;
    end else begin
      sram_oe = 1'b0;
    end
    if (!v.exp_win) begin
      repeat (3) begin
        @(negedge clock);
        chk("oow_busy", memory_busy, 0);
        chk("oow_req", bk_req, 0);
      end
    end else begin
      busy_cnt = 0;
      @(negedge clock);                      // s+2
      if (v.wr) sram_dat_in = ~v.wdata;      // must not reach the backing port
      while (memory_busy === 1'b1 && busy_cnt < 40) begin
        busy_cnt++;
        @(negedge clock);
      end
      chk("busy_len", busy_cnt, 1 + v.delay);
      chk("req_trains", req_trains - trains0, 1);
      chk("req_after_ack", bk_req, 0);
      if (v.wr) begin
        chk("dat_oe_write", sram_dat_oe, 0);
      end else begin
        chk("rd_data", sram_dat_out, v.rdata);
        chk("dat_oe_read", sram_dat_oe, 1);
        @(negedge clock);
        chk("rd_data_hold", sram_dat_out, v.rdata);
      end
    end
    sram_ce = 1'b1;
    sram_we = 1'b1;
    sram_oe = 1'b1;
    @(negedge clock);
    chk("dat_oe_idle", sram_dat_oe, 0);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int trains0;

    vecs[0] = '{1'b0, 23'h080123, 2'b00, 16'h0000, 16'hBEEF, 0, 1'b1, 18'h00123, 2'b11};
    vecs[1] = '{1'b1, 23'h080456, 2'b10, 16'h1234, 16'h0000, 3, 1'b1, 18'h00456, 2'b01};
    vecs[2] = '{1'b0, 23'h010000, 2'b00, 16'h0000, 16'h0000, 0, 1'b0, 18'h00000, 2'b00};
    vecs[3] = '{1'b1, 23'h0BFFFF, 2'b01, 16'hA5C3, 16'h0000, 1, 1'b1, 18'h3FFFF, 2'b10};
    vecs[4] = '{1'b0, 23'h080000, 2'b11, 16'h0000, 16'h0F0F, 2, 1'b1, 18'h00000, 2'b00};
    vecs[5] = '{1'b0, 23'h0C0000, 2'b00, 16'h0000, 16'h0000, 0, 1'b0, 18'h00000, 2'b00};
    vecs[6] = '{1'b1, 23'h07FFFF, 2'b00, 16'h5555, 16'h0000, 0, 1'b0, 18'h00000, 2'b00};
    vecs[7] = '{1'b1, 23'h0A5A5A, 2'b00, 16'hFFFF, 16'h0000, 0, 1'b1, 18'h25A5A, 2'b11};
    vecs[8] = '{1'b0, 23'h09ABCD, 2'b00, 16'h0000, 16'h1357, 4, 1'b1, 18'h1ABCD, 2'b11};

    reset_n     = 1'b0;
    sram_adr    = 23'h0;
    addr_strobe = 1'b0;
    sram_ce     = 1'b1;
    sram_we     = 1'b1;
    sram_oe     = 1'b1;
    sram_be     = 2'b11;
    sram_dat_in = 16'h0;

    // ---- reset state ----
    repeat (3) @(negedge clock);
    chk("rst_busy", memory_busy, 0);
    chk("rst_req", bk_req, 0);
    chk("rst_we", bk_we, 0);
    chk("rst_addr", bk_addr, 0);
    chk("rst_be", bk_be, 0);
    chk("rst_wdata", bk_wdata, 0);
    chk("rst_dat_out", sram_dat_out, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_dat_oe", sram_dat_oe, 0);
    #2 reset_n = 1'b1;

    // ---- table-driven accesses ----
    for (int i = 0; i < 9; i++) begin
      run_access(vecs[i]);
      $display("vec %0d adr=%h wr=%0d delay=%0d checks=%0d errors=%0d",
               i, vecs[i].adr, vecs[i].wr, vecs[i].delay, checks, errors);
    end
    chk("proto_err_clean", proto_err, 0);

    // ---- abort: CE stays high after the strobe ----
    trains0 = req_trains;
    @(negedge clock);
    sram_adr    = 23'h080010;
    addr_strobe = 1'b1;
    @(negedge clock);
    addr_strobe = 1'b0;
    chk("abort_busy_s1", memory_busy, 1);
    @(negedge clock);
    chk("abort_busy_s2", memory_busy, 0);
    chk("abort_req_s2", bk_req, 0);
    repeat (2) @(negedge clock);
    chk("abort_no_req", req_trains - trains0, 0);
    $display("seq abort checks=%0d errors=%0d", checks, errors);

    // ---- back-to-back reads with a strobe injected during BK ----
    @(negedge clock);                                  // s
    sram_adr    = 23'h080123;
    addr_strobe = 1'b1;
    sram_be     = 2'b00;
    sb_q.push_back('{1'b0, 18'h00123, 2'b11, 16'h0, 16'hBEEF, 0});
    @(negedge clock);                                  // s+1
    addr_strobe = 1'b0;
    sram_ce     = 1'b0;
    sram_oe     = 1'b0;
    chk("b2b_busy_s1", memory_busy, 1);
    @(negedge clock);                                  // s+2
    chk("b2b_busy_s2", memory_busy, 1);
    @(negedge clock);                                  // s+3, HOLD
    chk("b2b_busy_s3", memory_busy, 0);
    chk("b2b_rd1", sram_dat_out, 16'hBEEF);
    chk("b2b_oe1", sram_dat_oe, 1);
    sram_adr    = 23'h080124;
    addr_strobe = 1'b1;
    sb_q.push_back('{1'b0, 18'h00124, 2'b11, 16'h0, 16'hCAFE, 3});
    @(negedge clock);                                  // s'+1, ARM
    addr_strobe = 1'b0;
    chk("b2b2_busy", memory_busy, 1);
    chk("b2b2_addr", bk_addr, 18'h00124);
    chk("b2b2_oe_arm", sram_dat_oe, 0);
    @(negedge clock);                                  // s'+2, BK
    chk("b2b2_req", bk_req, 1);
    chk("b2b2_proto_before", proto_err, 0);
    sram_adr    = 23'h080200;
    addr_strobe = 1'b1;
    @(negedge clock);                                  // s'+3
    addr_strobe = 1'b0;
    sram_adr    = 23'h080124;
    chk("b2b2_proto_after", proto_err, 1);
    cnt = 0;
    while (memory_busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clock);
    end
    chk("b2b2_release", memory_busy, 0);
    chk("b2b2_rd", sram_dat_out, 16'hCAFE);
    chk("b2b2_oe", sram_dat_oe, 1);
    chk("b2b2_addr_kept", bk_addr, 18'h00124);
    sram_ce = 1'b1;
    sram_oe = 1'b1;
    @(negedge clock);
    chk("b2b_sb_drained", sb_q.size(), 0);
    chk("proto_sticky", proto_err, 1);
    $display("seq back_to_back checks=%0d errors=%0d", checks, errors);

    // ---- asynchronous reset while bk_req is high ----
    @(negedge clock);
    sram_adr    = 23'h0BFFFF;
    addr_strobe = 1'b1;
    sram_be     = 2'b00;
    sb_q.push_back('{1'b1, 18'h3FFFF, 2'b11, 16'h7E7E, 16'h0, 10});
    @(negedge clock);
    addr_strobe = 1'b0;
    sram_ce     = 1'b0;
    sram_we     = 1'b0;
    sram_dat_in = 16'h7E7E;
    cnt = 0;
    while (bk_req !== 1'b1 && cnt < 10) begin
      cnt++;
      @(negedge clock);
    end
    chk("rst_seq_req_seen", bk_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", bk_req, 0);
    chk("arst_busy", memory_busy, 0);
    chk("arst_we", bk_we, 0);
    chk("arst_addr", bk_addr, 0);
    chk("arst_wdata", bk_wdata, 0);
    chk("arst_proto_err", proto_err, 0);
    chk("arst_dat_out", sram_dat_out, 0);
    @(negedge clock);
    sram_ce = 1'b1;
    sram_we = 1'b1;
    #2 reset_n = 1'b1;
    $display("seq async_reset checks=%0d errors=%0d", checks, errors);

    // Normal access after reset release.
    run_access(vecs[0]);
    run_access(vecs[1]);
    chk("post_rst_proto", proto_err, 0);
    $display("seq post_reset checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
